simple_axi_to_axi_read: RTL and testbench

- AXI4 read master that turns a single simple-bus read request (address + byte length) into one or more INCR AXI read bursts.
- Returned beats are streamed back to the requester with backpressure.
- Read-side counterpart of the simple-to-AXI write bridge; sits between Versat data sources and the shared AXI interconnect.

---
 rtl/simple_axi_to_axi_read.sv | 169 ++++++++++++++++
 tb/tb_simple_axi_to_axi_read.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_axi_to_axi_read.sv
// Simple-bus read request to AXI4 INCR read bursts, beats streamed back with backpressure.
// Optional SIMPLE_AXI_READ_4K_SPLIT_EN: also cap each burst at the next 4 KB boundary.
module simple_axi_to_axi_read #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int LEN_W      = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  m_rvalid_i,
  input  logic [AXI_ADDR_W-1:0] m_raddr_i,
  input  logic [LEN_W-1:0]      m_rlen_i,
  output logic                  m_rdata_valid_o,
  output logic [AXI_DATA_W-1:0] m_rdata_o,
  input  logic                  m_rdata_ready_i,
  output logic                  m_rlast_o,
  output logic                  m_rdone_o,
  output logic                  m_rerror_o,
  output logic [AXI_ID_W-1:0]   axi_arid_o,
  output logic [AXI_ADDR_W-1:0] axi_araddr_o,
  output logic [AXI_LEN_W-1:0]  axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  output logic                  axi_arlock_o,
  output logic [3:0]            axi_arcache_o,
  output logic [2:0]            axi_arprot_o,
  output logic [3:0]            axi_arqos_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  input  logic [AXI_ID_W-1:0]   axi_rid_i,
  input  logic [AXI_DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [31:0] MAX_BEATS = 32'd1 << AXI_LEN_W;

  state_t                state;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [AXI_ADDR_W-1:0] araddr_q;
  logic [31:0]           remaining;
  logic [AXI_LEN_W-1:0]  arlen_q;
  logic [AXI_LEN_W-1:0]  beat_cnt;
  logic                  arvalid_q;
  logic                  rdone_q;
  logic                  rerror_q;

  logic [31:0] req_beats;
  logic [31:0] burst_beats;
  logic [31:0] cur_beats;
  logic        in_data;
  logic        last_cnt;
  logic        r_hs;
  logic        unused_bits;

  assign req_beats = ((32'(m_rlen_i) - 32'd1) >> 2) + 32'd1;
  assign cur_beats = 32'(arlen_q) + 32'd1;

`ifdef SIMPLE_AXI_READ_4K_SPLIT_EN
  logic [31:0] beats_to_4k;
  assign beats_to_4k = 32'((13'h1000 - {1'b0, addr_q[11:0]}) >> 2);
`endif

  always_comb begin
    burst_beats = (remaining > MAX_BEATS) ? MAX_BEATS : remaining;
`ifdef SIMPLE_AXI_READ_4K_SPLIT_EN
    if (burst_beats > beats_to_4k) burst_beats = beats_to_4k;
`endif
  end

  // R channel is a zero-latency pass-through while a burst is in flight
  assign in_data         = (state == S_DATA);
  assign last_cnt        = (beat_cnt == arlen_q);
  assign r_hs            = in_data & axi_rvalid_i & m_rdata_ready_i;
  assign m_rdata_valid_o = in_data & axi_rvalid_i;
  assign m_rdata_o       = in_data ? axi_rdata_i : '0;
  assign axi_rready_o    = in_data & m_rdata_ready_i;
  assign m_rlast_o       = in_data & last_cnt & (remaining == 32'd0);
  assign m_rdone_o       = rdone_q;
  assign m_rerror_o      = rerror_q;

  assign axi_arid_o    = '0;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = arlen_q;
  assign axi_arsize_o  = 3'b010;
  assign axi_arburst_o = 2'b01;
  assign axi_arlock_o  = 1'b0;
  assign axi_arcache_o = '0;
  assign axi_arprot_o  = '0;
  assign axi_arqos_o   = '0;
  assign axi_arvalid_o = arvalid_q;

  assign unused_bits = ^{axi_rid_i, m_raddr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      araddr_q  <= '0;
      remaining <= '0;
      arlen_q   <= '0;
      beat_cnt  <= '0;
      arvalid_q <= 1'b0;
      rdone_q   <= 1'b0;
      rerror_q  <= 1'b0;
    end else begin
      rdone_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (m_rvalid_i) begin
            if (m_rlen_i != '0) begin
              addr_q    <= {m_raddr_i[AXI_ADDR_W-1:2], 2'b00};
              remaining <= req_beats;
              rerror_q  <= 1'b0;
              state     <= S_CALC;
            end else begin
              rdone_q <= 1'b1;
            end
          end
        end
        S_CALC: begin
          arlen_q   <= AXI_LEN_W'(burst_beats - 32'd1);
          araddr_q  <= addr_q;
          arvalid_q <= 1'b1;
          state     <= S_ADDR;
        end
        S_ADDR: begin
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            beat_cnt  <= '0;
            addr_q    <= addr_q + AXI_ADDR_W'(cur_beats << 2);
            remaining <= remaining - cur_beats;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + AXI_LEN_W'(1);
            // burst end follows our own count; a disagreeing rlast only flags an error
            if ((axi_rresp_i != 2'b00) || (axi_rlast_i != last_cnt)) rerror_q <= 1'b1;
            if (last_cnt) state <= S_GAP;
          end
        end
        S_GAP: begin
          if (remaining == 32'd0) begin
            rdone_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            state <= S_CALC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_axi_to_axi_read.sv
// Directed bench for simple_axi_to_axi_read: table of requests against a small AXI slave model.
module tb_simple_axi_to_axi_read;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_rvalid;
  logic [31:0] m_raddr;
  logic [19:0] m_rlen;
  logic        m_rdata_valid;
  logic [31:0] m_rdata;
  logic        m_rdata_ready;
  logic        m_rlast;
  logic        m_rdone;
  logic        m_rerror;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  simple_axi_to_axi_read #(
    .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_LEN_W(8), .AXI_ID_W(1), .LEN_W(20)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_rvalid_i(m_rvalid), .m_raddr_i(m_raddr), .m_rlen_i(m_rlen),
    .m_rdata_valid_o(m_rdata_valid), .m_rdata_o(m_rdata), .m_rdata_ready_i(m_rdata_ready),
    .m_rlast_o(m_rlast), .m_rdone_o(m_rdone), .m_rerror_o(m_rerror),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache),
    .axi_arprot_o(arprot), .axi_arqos_o(arqos), .axi_arvalid_o(arvalid),
    .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  localparam logic [31:0] DPAT = 32'h5A5A_0000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // slave model state and monitor records
  logic [31:0] bq_addr[$];
  int          bq_len[$];
  int          beat_idx, tot_beats, ar_wait, ar_delay, rdy_mode;
  int          err_resp_at, err_last_at;
  logic        ar_hs_p, r_hs_p, prev_arv, prev_hs;
  logic [31:0] cap_addr, prev_addr;
  int          cap_len, prev_len;
  logic [31:0] got_addr[$];
  int          got_len[$];
  logic [31:0] got_data[$];
  logic        got_last[$];
  int          arv_viol, rdy_viol, arv_seen, rdone_cnt, cyc, last_hs_cyc, rdone_cyc;

  initial begin
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0; m_rdata_ready = 0;
    beat_idx = 0; tot_beats = 0; ar_wait = 0; ar_delay = 0; rdy_mode = 0;
    err_resp_at = -1; err_last_at = -1; ar_hs_p = 0; r_hs_p = 0; prev_arv = 0; prev_hs = 0;
    cap_addr = '0; prev_addr = '0; cap_len = 0; prev_len = 0;
    arv_viol = 0; rdy_viol = 0; arv_seen = 0; rdone_cnt = 0; cyc = 0; last_hs_cyc = 0; rdone_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        bq_addr.delete(); bq_len.delete();
        beat_idx = 0; ar_wait = 0; ar_hs_p = 0; r_hs_p = 0; prev_arv = 0; prev_hs = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = '0; rdata = '0; m_rdata_ready = 0;
      end else begin
        if (ar_hs_p) begin
          bq_addr.push_back(cap_addr); bq_len.push_back(cap_len);
        end
        if (r_hs_p) begin
          beat_idx++; tot_beats++;
          if (beat_idx > bq_len[0]) begin
            void'(bq_addr.pop_front()); void'(bq_len.pop_front()); beat_idx = 0;
          end
        end
        if (arvalid) begin
          arready = (ar_wait >= ar_delay);
          ar_wait++;
        end else begin
          arready = 0; ar_wait = 0;
        end
        if (bq_len.size() > 0) begin
          rvalid = 1;
          rdata  = (bq_addr[0] + 32'(beat_idx * 4)) ^ DPAT;
          rresp  = (tot_beats == err_resp_at) ? 2'b10 : 2'b00;
          rlast  = (beat_idx == bq_len[0]) ^ (tot_beats == err_last_at);
        end else begin
          rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
        end
        m_rdata_ready = (rdy_mode != 0) ? ~m_rdata_ready : 1'b1;
        #1;
        if (arvalid) arv_seen++;
        ar_hs_p = arvalid && arready;
        cap_addr = araddr; cap_len = int'(arlen);
        if (ar_hs_p) begin
          got_addr.push_back(araddr); got_len.push_back(int'(arlen));
        end
        if (prev_arv && !prev_hs && (!arvalid || araddr != prev_addr || int'(arlen) != prev_len))
          arv_viol++;
        prev_arv = arvalid; prev_hs = ar_hs_p; prev_addr = araddr; prev_len = int'(arlen);
        if (rready !== ((bq_len.size() > 0) && m_rdata_ready)) rdy_viol++;
        if ((bq_len.size() == 0) && m_rdata_valid) rdy_viol++;
        r_hs_p = m_rdata_valid && m_rdata_ready;
        if (r_hs_p) begin
          got_data.push_back(m_rdata); got_last.push_back(m_rlast); last_hs_cyc = cyc;
        end
        if (m_rdone) begin
          rdone_cnt++; rdone_cyc = cyc;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [19:0] len;
    int          mode;
    int          ardly;
    int          nb;
    logic [31:0] a0;
    int          l0;
    logic [31:0] a1;
    int          l1;
    int          beats;
  } vec_t;

  vec_t vecs[7];

  task automatic run_req(input logic [31:0] a, input logic [19:0] l, output int done);
    got_addr.delete(); got_len.delete(); got_data.delete(); got_last.delete();
    rdone_cnt = 0; tot_beats = 0; arv_viol = 0; rdy_viol = 0;
    @(posedge clk); #1;
    m_rvalid = 1; m_raddr = a; m_rlen = l;
    @(posedge clk); #1;
    m_rvalid = 0;
    done = 0;
    for (int i = 0; i < 3000 && done == 0; i++) begin
      @(posedge clk); #1;
      if (m_rdone) done = 1;
    end
    @(negedge clk); #2;
  endtask

  task automatic check_run(input string tag, input vec_t v, input int done);
    int bad_words, n_last;
    logic [31:0] base;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".n_bursts"}, got_addr.size(), v.nb);
    if (got_addr.size() > 0) begin
      chk({tag, ".araddr0"}, got_addr[0], v.a0);
      chk({tag, ".arlen0"}, got_len[0], v.l0);
    end
    if (v.nb > 1 && got_addr.size() > 1) begin
      chk({tag, ".araddr1"}, got_addr[1], v.a1);
      chk({tag, ".arlen1"}, got_len[1], v.l1);
    end
    chk({tag, ".beats"}, got_data.size(), v.beats);
    base = {v.addr[31:2], 2'b00};
    bad_words = 0; n_last = 0;
    for (int k = 0; k < got_data.size(); k++) begin
      if (got_data[k] !== ((base + 32'(k * 4)) ^ DPAT)) bad_words++;
      if (got_last[k]) n_last++;
    end
    chk({tag, ".bad_words"}, bad_words, 0);
    chk({tag, ".rlast_count"}, n_last, 1);
    chk({tag, ".rlast_final"}, (got_last.size() > 0) ? got_last[got_last.size()-1] : 1'b0, 1);
    chk({tag, ".rdone_pulses"}, rdone_cnt, 1);
    chk({tag, ".rdone_latency"}, rdone_cyc - last_hs_cyc, 2);
    chk({tag, ".arvalid_stable"}, arv_viol, 0);
    chk({tag, ".rready_mirror"}, rdy_viol, 0);
    chk({tag, ".rerror"}, m_rerror, 0);
  endtask

  initial begin
    int done;
    vec_t ev;
    vecs[0] = '{32'h1000, 20'd16,   0, 5, 1, 32'h1000, 3,   32'h0,    0, 4};
    vecs[1] = '{32'h2000, 20'd1030, 0, 0, 2, 32'h2000, 255, 32'h2400, 1, 258};
    vecs[2] = '{32'h3000, 20'd32,   1, 1, 1, 32'h3000, 7,   32'h0,    0, 8};
    vecs[3] = '{32'h4003, 20'd5,    0, 0, 1, 32'h4000, 1,   32'h0,    0, 2};
    vecs[4] = '{32'h5000, 20'd1024, 0, 2, 1, 32'h5000, 255, 32'h0,    0, 256};
`ifdef SIMPLE_AXI_READ_4K_SPLIT_EN
    vecs[5] = '{32'h0FF0, 20'd64,   0, 0, 2, 32'h0FF0, 3,   32'h1000, 11, 16};
`else
    vecs[5] = '{32'h0FF0, 20'd64,   0, 0, 1, 32'h0FF0, 15,  32'h0,    0, 16};
`endif
    vecs[6] = '{32'h6000, 20'd4,    1, 0, 1, 32'h6000, 0,   32'h0,    0, 1};

    rst_n = 0; m_rvalid = 0; m_raddr = '0; m_rlen = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.arvalid", arvalid, 0);
    chk("rst.rdata_valid", m_rdata_valid, 0);
    chk("rst.rlast", m_rlast, 0);
    chk("rst.rdone", m_rdone, 0);
    chk("rst.rerror", m_rerror, 0);
    chk("rst.rready", rready, 0);
    chk("rst.arsize", arsize, 3'b010);
    chk("rst.arburst", arburst, 2'b01);
    rst_n = 1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      rdy_mode = vecs[i].mode; ar_delay = vecs[i].ardly;
      run_req(vecs[i].addr, vecs[i].len, done);
      check_run($sformatf("vec%0d", i), vecs[i], done);
    end
    rdy_mode = 0; ar_delay = 0;

    // zero-length request: rdone next cycle, no AR traffic
    arv_seen = 0; got_addr.delete();
    @(posedge clk); #1;
    m_rvalid = 1; m_raddr = 32'h7000; m_rlen = '0;
    @(posedge clk); #1;
    m_rvalid = 0;
    chk("len0.rdone_pulse", m_rdone, 1);
    @(posedge clk); #1;
    chk("len0.rdone_drop", m_rdone, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("len0.no_arvalid", arv_seen, 0);
    chk("len0.no_bursts", got_addr.size(), 0);

    // bad rresp on beat 2, then early rlast on beat 3; error sticks past rdone
    err_resp_at = 1;
    run_req(32'h8000, 20'd16, done);
    err_resp_at = -1;
    chk("rresp_err.done", done, 1);
    chk("rresp_err.beats", got_data.size(), 4);
    chk("rresp_err.rerror", m_rerror, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rresp_err.sticky", m_rerror, 1);
    err_last_at = 2;
    run_req(32'h8100, 20'd16, done);
    err_last_at = -1;
    chk("rlast_err.done", done, 1);
    chk("rlast_err.beats", got_data.size(), 4);
    chk("rlast_err.rerror", m_rerror, 1);
    ev = '{32'h8200, 20'd8, 0, 0, 1, 32'h8200, 1, 32'h0, 0, 2};
    run_req(ev.addr, ev.len, done);
    check_run("err_clear", ev, done);

    // reset in the middle of a data burst
    got_data.delete();
    @(posedge clk); #1;
    m_rvalid = 1; m_raddr = 32'h9000; m_rlen = 20'd64;
    @(posedge clk); #1;
    m_rvalid = 0;
    done = 0;
    for (int i = 0; i < 100 && done == 0; i++) begin
      @(posedge clk); #1;
      if (got_data.size() >= 3 && m_rdata_valid) done = 1;
    end
    chk("midrst.reached_data", done, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("midrst.arvalid", arvalid, 0);
    chk("midrst.rdata_valid", m_rdata_valid, 0);
    chk("midrst.rlast", m_rlast, 0);
    chk("midrst.rdone", m_rdone, 0);
    chk("midrst.rerror", m_rerror, 0);
    chk("midrst.rready", rready, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk);
    ev = '{32'hA000, 20'd12, 1, 3, 1, 32'hA000, 2, 32'h0, 0, 3};
    rdy_mode = ev.mode; ar_delay = ev.ardly;
    run_req(ev.addr, ev.len, done);
    check_run("post_rst", ev, done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
